// File: rtl/sort_floats_pkg.sv
// Shared types and elaboration helpers for the odd-even transposition float sorter.
// FLEN falls back to 64 (FP64) when the shared config header has not defined it.
`ifndef FLEN
`define FLEN 64
`endif

package sort_floats_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSort,
        StDone
    } state_e;

    // Counter must reach N without wrapping.
    function automatic int unsigned phase_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Lower element index handled by comparator k in phase parity p.
    function automatic int unsigned pair_lo(input int unsigned k, input int unsigned p);
        return 2 * k + p;
    endfunction

    function automatic int unsigned exp_width(input int unsigned flen);
        case (flen)
            16:      return 5;
            32:      return 8;
            128:     return 15;
            default: return 11;
        endcase
    endfunction

endpackage

// File: rtl/f_less_or_equal.sv
// IEEE-754 a <= b compare; err flags a NaN operand, in which case res is 0.
// Signed zeros compare equal.
`ifndef FLEN
`define FLEN 64
`endif

module f_less_or_equal
    import sort_floats_pkg::*;
(
    input  logic [`FLEN-1:0] a,
    input  logic [`FLEN-1:0] b,
    output logic             res,
    output logic             err
);

    localparam int unsigned NE = exp_width(`FLEN);
    localparam int unsigned NM = `FLEN - 1 - NE;

    logic             nan_a, nan_b, both_zero;
    logic [`FLEN-2:0] mag_a, mag_b;

    assign mag_a     = a[`FLEN-2:0];
    assign mag_b     = b[`FLEN-2:0];
    assign nan_a     = (&a[`FLEN-2 -: NE]) & (|a[NM-1:0]);
    assign nan_b     = (&b[`FLEN-2 -: NE]) & (|b[NM-1:0]);
    assign both_zero = ~|mag_a & ~|mag_b;
    assign err       = nan_a | nan_b;

    always_comb begin
        res = 1'b0;
        if (err) begin
            res = 1'b0;
        end else if (both_zero) begin
            res = 1'b1;
        end else begin
            case ({a[`FLEN-1], b[`FLEN-1]})
                2'b00:   res = (mag_a <= mag_b);
                2'b01:   res = 1'b0;
                2'b10:   res = 1'b1;
                default: res = (mag_a >= mag_b);
            endcase
        end
    end

endmodule

// File: rtl/sort_floats_cas.sv
// Compare-and-swap unit: orders one float pair when enabled, otherwise passes it through.
`ifndef FLEN
`define FLEN 64
`endif

module sort_floats_cas (
    input  logic [`FLEN-1:0] a,
    input  logic [`FLEN-1:0] b,
    input  logic             en,
    output logic [`FLEN-1:0] lo,
    output logic [`FLEN-1:0] hi,
    output logic             swapped,
    output logic             err
);

    logic le, cmp_err;

    f_less_or_equal u_cmp (
        .a   (a),
        .b   (b),
        .res (le),
        .err (cmp_err)
    );

    // Equal or unordered pairs keep their order, which keeps the sort stable.
    assign swapped = en & ~le & ~cmp_err;
    assign err     = en & cmp_err;
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/sort_floats_oets.sv
// Sequential odd-even transposition sorter for N floats with valid/ready on both sides.
// Define SORT_FLOATS_EARLY_EXIT_EN to stop after two consecutive swap-free phases.
`ifndef FLEN
`define FLEN 64
`endif

module sort_floats_oets
    import sort_floats_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [0:N-1][`FLEN-1:0]    up_data,
    output logic                       down_valid,
    input  logic                       down_ready,
    output logic [0:N-1][`FLEN-1:0]    down_data,
    output logic                       down_err
);

    localparam int unsigned NC = N / 2;
    localparam int unsigned CW = phase_cnt_width(N);

    state_e                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [0:N-1][`FLEN-1:0]     data_q, data_d, sorted;
    logic                        err_q, err_d;
    logic                        in_sort, phase_odd, last_phase;
    logic [NC-1:0][`FLEN-1:0]    cas_lo, cas_hi;
    logic [NC-1:0]               cas_swp, cas_err;

    assign in_sort   = (state_q == StSort);
    assign phase_odd = cnt_q[0];

    for (genvar k = 0; k < NC; k++) begin : g_cas
        localparam int unsigned LoE = pair_lo(k, 0);
        localparam int unsigned LoO = pair_lo(k, 1);
        logic [`FLEN-1:0] a, b;
        logic             en;
        if (LoO + 1 < N) begin : g_both
            assign a  = phase_odd ? data_q[LoO] : data_q[LoE];
            assign b  = phase_odd ? data_q[LoO+1] : data_q[LoE+1];
            assign en = in_sort;
        end else begin : g_even_only
            assign a  = data_q[LoE];
            assign b  = data_q[LoE+1];
            assign en = in_sort & ~phase_odd;
        end
        sort_floats_cas u_cas (
            .a       (a),
            .b       (b),
            .en      (en),
            .lo      (cas_lo[k]),
            .hi      (cas_hi[k]),
            .swapped (cas_swp[k]),
            .err     (cas_err[k])
        );
    end

    // Route each element from the comparator that owns it in the current phase.
    for (genvar i = 0; i < N; i++) begin : g_elem
        logic [`FLEN-1:0] ev, od;
        if (i % 2 == 0) begin : g_even_idx
            if (i + 1 < N) begin : g_ev
                assign ev = cas_lo[i/2];
            end else begin : g_ev_hold
                assign ev = data_q[i];
            end
            if (i == 0) begin : g_od_hold
                assign od = data_q[0];
            end else begin : g_od
                assign od = cas_hi[(i-1)/2];
            end
        end else begin : g_odd_idx
            assign ev = cas_hi[(i-1)/2];
            if (i + 1 < N) begin : g_od
                assign od = cas_lo[(i-1)/2];
            end else begin : g_od_hold
                assign od = data_q[i];
            end
        end
        assign sorted[i] = phase_odd ? od : ev;
    end

`ifdef SORT_FLOATS_EARLY_EXIT_EN
    logic quiet_q, quiet_d;

    assign last_phase = (cnt_q == CW'(N - 1)) | (quiet_q & ~|cas_swp);

    always_comb begin
        quiet_d = quiet_q;
        if (state_q == StIdle) begin
            quiet_d = 1'b0;
        end else if (in_sort) begin
            quiet_d = ~|cas_swp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_q <= 1'b0;
        end else begin
            quiet_q <= quiet_d;
        end
    end
`else
    logic unused_swp;

    assign unused_swp = ^cas_swp;
    assign last_phase = (cnt_q == CW'(N - 1));
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        up_ready   = 1'b0;
        down_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                up_ready = 1'b1;
                if (up_valid) begin
                    data_d  = up_data;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StSort;
                end
            end
            StSort: begin
                data_d = sorted;
                err_d  = err_q | (|cas_err);
                cnt_d  = cnt_q + 1'b1;
                if (last_phase) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                down_valid = 1'b1;
                if (down_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign down_data = data_q;
    assign down_err  = err_q;

endmodule

// File: tb/tb_sort_floats_oets.sv
// Self-checking bench for sort_floats_oets: N=4, N=3 and N=8 instances share one stimulus bus.
// Expected vectors, error flags and phase counts come from a real-valued phase model.
`ifndef FLEN
`define FLEN 64
`endif

module tb_sort_floats_oets;

    localparam logic [63:0] P1   = 64'h3FF0000000000000;
    localparam logic [63:0] P2   = 64'h4000000000000000;
    localparam logic [63:0] P3   = 64'h4008000000000000;
    localparam logic [63:0] M1   = 64'hBFF0000000000000;
    localparam logic [63:0] M3   = 64'hC008000000000000;
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;
    localparam logic [63:0] PZ   = 64'h0000000000000000;
    localparam logic [63:0] MZ   = 64'h8000000000000000;
    localparam logic [63:0] P1U  = 64'h3FF0000000000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, up_valid, down_ready;
    logic [0:7][63:0]  up_data_all;
    int                sel;
    logic [2:0]        uv, ur, dv, de;
    logic [0:3][63:0]  dd4;
    logic [0:2][63:0]  dd3;
    logic [0:7][63:0]  dd8;
    logic [0:7][63:0]  dd_m;
    logic              ur_m, dv_m, de_m;
    int                errors = 0;
    int                checks = 0;

    assign uv[0] = up_valid && (sel == 0);
    assign uv[1] = up_valid && (sel == 1);
    assign uv[2] = up_valid && (sel == 2);

    sort_floats_oets #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .up_valid(uv[0]), .up_ready(ur[0]),
        .up_data(up_data_all[0:3]), .down_valid(dv[0]), .down_ready(down_ready),
        .down_data(dd4), .down_err(de[0])
    );
    sort_floats_oets #(.N(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .up_valid(uv[1]), .up_ready(ur[1]),
        .up_data(up_data_all[0:2]), .down_valid(dv[1]), .down_ready(down_ready),
        .down_data(dd3), .down_err(de[1])
    );
    sort_floats_oets #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .up_valid(uv[2]), .up_ready(ur[2]),
        .up_data(up_data_all), .down_valid(dv[2]), .down_ready(down_ready),
        .down_data(dd8), .down_err(de[2])
    );

    always_comb begin
        dd_m = '0;
        ur_m = ur[0];
        dv_m = dv[0];
        de_m = de[0];
        case (sel)
            1: begin
                for (int i = 0; i < 3; i++) dd_m[i] = dd3[i];
                ur_m = ur[1]; dv_m = dv[1]; de_m = de[1];
            end
            2: begin
                dd_m = dd8;
                ur_m = ur[2]; dv_m = dv[2]; de_m = de[2];
            end
            default: begin
                for (int i = 0; i < 4; i++) dd_m[i] = dd4[i];
            end
        endcase
    end

    function automatic bit is_nan(input logic [63:0] x);
        return (&x[62:52]) && (|x[51:0]);
    endfunction

    // Sequential odd-even passes on real values; NaN pairs flag err and stay put.
    function automatic void model(input logic [0:7][63:0] in, input int n,
                                  output logic [0:7][63:0] out, output bit err,
                                  output int phases);
        logic [63:0] t;
        bit          sw;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
        bit          prev_quiet = 1'b0;
`endif
        out = in; err = 1'b0; phases = 0;
        for (int p = 0; p < n; p++) begin
            sw = 1'b0;
            for (int i = p % 2; i + 1 < n; i += 2) begin
                if (is_nan(out[i]) || is_nan(out[i+1])) begin
                    err = 1'b1;
                end else if ($bitstoreal(out[i]) > $bitstoreal(out[i+1])) begin
                    t = out[i]; out[i] = out[i+1]; out[i+1] = t; sw = 1'b1;
                end
            end
            phases++;
`ifdef SORT_FLOATS_EARLY_EXIT_EN
            if (!sw && prev_quiet) break;
            prev_quiet = !sw;
`endif
        end
        for (int i = n; i < 8; i++) out[i] = '0;
    endfunction

    function automatic logic [63:0] pick(input int unsigned r);
        case (r)
            0: return P1;  1: return P2;  2: return P3;  3: return M1;  4: return M3;
            5: return PZ;  6: return MZ;  7: return P1U;
            default: return QNAN;
        endcase
    endfunction

    task automatic run_vec(input int s, input int n, input logic [0:7][63:0] v, input int hold,
                           input string name, output logic [0:7][63:0] got,
                           output logic got_err, output int lat);
        logic [0:7][63:0] exp;
        bit               eerr;
        int               eph;
        model(v, n, exp, eerr, eph);
        sel = s;
        down_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ur_m !== 1'b1) begin
            errors++;
            $display("FAIL %s up_ready before accept: got %b want 1", name, ur_m);
        end
        up_data_all = v;
        up_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        up_valid = 1'b0;
        lat = 0;
        while (dv_m !== 1'b1 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != eph) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", name, lat + 1, eph + 1);
        end
        for (int h = 0; h < hold; h++) begin
            up_valid = 1'b1;
            up_data_all = ~v;
            checks++;
            if (dv_m !== 1'b1 || ur_m !== 1'b0 || dd_m !== exp || de_m !== eerr) begin
                errors++;
                $display("FAIL %s hold cycle %0d: valid=%b ready=%b err=%b data=%h want err=%b data=%h",
                         name, h, dv_m, ur_m, de_m, dd_m, eerr, exp);
            end
            @(posedge clk);
            @(negedge clk);
        end
        up_valid = 1'b0;
        got = dd_m;
        got_err = de_m;
        checks++;
        if (dd_m !== exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, dd_m, exp);
        end
        checks++;
        if (de_m !== eerr) begin
            errors++;
            $display("FAIL %s err: got %b want %b", name, de_m, eerr);
        end
        down_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        down_ready = 1'b0;
        checks++;
        if (dv_m !== 1'b0 || ur_m !== 1'b1) begin
            errors++;
            $display("FAIL %s after handshake: valid=%b ready=%b want 0/1", name, dv_m, ur_m);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; up_valid = 1'b0; down_ready = 1'b0; sel = 0; up_data_all = '0;
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (dv_m !== 1'b0 || dd_m !== '0 || de_m !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: valid=%b err=%b data=%h want 0", s, dv_m, de_m, dd_m);
            end
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ur_m !== 1'b1) begin
            errors++;
            $display("FAIL reset up_ready: got %b want 1", ur_m);
        end
    endtask

    task automatic test_basic();
        logic [0:7][63:0] got, want;
        logic             ge;
        int               lat;
        run_vec(0, 4, {P3, M1, P2, P1, {4{64'h0}}}, 0, "basic", got, ge, lat);
        want = {M1, P1, P2, P3, {4{64'h0}}};
        checks++;
        if (got !== want || ge !== 1'b0) begin
            errors++;
            $display("FAIL basic const: got %h err=%b want %h err=0", got, ge, want);
        end
`ifndef SORT_FLOATS_EARLY_EXIT_EN
        checks++;
        if (lat + 1 != 5) begin
            errors++;
            $display("FAIL basic latency const: got %0d want 5", lat + 1);
        end
`endif
    endtask

    task automatic test_stable();
        logic [0:7][63:0] got, want;
        logic             ge;
        int               lat;
        run_vec(0, 4, {P1, P1, M1, P1, {4{64'h0}}}, 0, "equal", got, ge, lat);
        want = {M1, P1, P1, P1, {4{64'h0}}};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL equal const: got %h want %h", got, want);
        end
        // +0 and -0 compare equal but are distinguishable, so they expose ordering.
        run_vec(0, 4, {PZ, P1, MZ, M1, {4{64'h0}}}, 0, "stable", got, ge, lat);
        want = {M1, PZ, MZ, P1, {4{64'h0}}};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL stable const: got %h want %h", got, want);
        end
    endtask

    task automatic test_nan();
        logic [0:7][63:0] got;
        logic             ge;
        int               lat;
        run_vec(1, 3, {P1, QNAN, M1, {5{64'h0}}}, 0, "nan", got, ge, lat);
        checks++;
        if (ge !== 1'b1) begin
            errors++;
            $display("FAIL nan err const: got %b want 1", ge);
        end
    endtask

    task automatic test_hold();
        logic [0:7][63:0] got;
        logic             ge;
        int               lat;
        run_vec(0, 4, {P2, P3, P1, M3, {4{64'h0}}}, 10, "hold", got, ge, lat);
    endtask

    task automatic test_reset_mid_sort();
        logic [0:7][63:0] got;
        logic             ge;
        int               lat;
        sel = 0;
        @(negedge clk);
        up_data_all = {P3, P2, P1, M1, {4{64'h0}}};
        up_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        up_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (dv_m !== 1'b0 || dd_m !== '0 || de_m !== 1'b0) begin
            errors++;
            $display("FAIL midreset outputs: valid=%b err=%b data=%h want 0", dv_m, de_m, dd_m);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ur_m !== 1'b1 || dv_m !== 1'b0) begin
            errors++;
            $display("FAIL midreset release: ready=%b valid=%b want 1/0", ur_m, dv_m);
        end
        run_vec(0, 4, {P1, M3, P3, MZ, {4{64'h0}}}, 0, "after_reset", got, ge, lat);
    endtask

    task automatic test_n8();
        logic [0:7][63:0] got;
        logic             ge;
        int               lat;
        int               want_lat;
        run_vec(2, 8, {M3, M1, MZ, P1, P1U, P2, P3, P3}, 0, "n8_sorted", got, ge, lat);
`ifdef SORT_FLOATS_EARLY_EXIT_EN
        want_lat = 3;
`else
        want_lat = 9;
`endif
        checks++;
        if (lat + 1 != want_lat) begin
            errors++;
            $display("FAIL n8_sorted latency const: got %0d want %0d", lat + 1, want_lat);
        end
        run_vec(2, 8, {P3, P3, P2, P1U, P1, MZ, M1, M3}, 0, "n8_reversed", got, ge, lat);
        checks++;
        if (lat + 1 != 9) begin
            errors++;
            $display("FAIL n8_reversed latency const: got %0d want 9", lat + 1);
        end
    endtask

    task automatic test_random();
        logic [0:7][63:0] v, got;
        logic             ge;
        int               lat;
        int               n;
        for (int t = 0; t < 24; t++) begin
            int s;
            s = t % 3;
            n = (s == 0) ? 4 : (s == 1) ? 3 : 8;
            for (int i = 0; i < 8; i++) begin
                // NaN (index 8) appears roughly one draw in twenty.
                v[i] = (i < n) ? pick(($urandom_range(0, 19) == 0) ? 8 : $urandom_range(0, 7))
                               : 64'h0;
            end
            run_vec(s, n, v, 0, "random", got, ge, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stable();
        test_nan();
        test_hold();
        test_reset_mid_sort();
        test_n8();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
